// File: rtl/jk_pkg.sv
// Shared JK drive codes and default width for the JK-based frequency divider.
package jk_pkg;

    localparam int unsigned WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_code_t;

endpackage

// File: rtl/jk_cell.sv
// One-bit JK element with synchronous active-high reset; qb is always the complement of q.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            case (jk_code_t'({j, k}))
                JK_HOLD:   r_q <= r_q;
                JK_RESET:  r_q <= 1'b0;
                JK_SET:    r_q <= 1'b1;
                JK_TOGGLE: r_q <= ~r_q;
                default:   r_q <= r_q;
            endcase
        end
    end

    assign q  = r_q;
    assign qb = ~r_q;

endmodule

// File: rtl/jk_freq_divider.sv
// Programmable modulo-(N+1) counter built from JK cells, with a registered wrap pulse
// and a toggle output that divides the enabled clock rate by 2*(N+1).
module jk_freq_divider
    import jk_pkg::*;
#(
    parameter int unsigned       WIDTH   = WIDTH_DEF,
    parameter logic [WIDTH-1:0]  DIV_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] div_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             q,
    output logic             qb
);

    logic [WIDTH-1:0] r_div;
    logic             r_tc;
    logic [WIDTH-1:0] w_cnt_qb;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_match;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_run;
    logic             w_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= DIV_RST;
            r_tc  <= 1'b0;
        end else begin
            if (load) begin
                r_div <= div_val;
            end
            r_tc <= w_wrap;
        end
    end

    // Bit equality taken from whichever cell output matches the divisor bit.
    always_comb begin
        w_carry = '0;
        w_match = '0;
        w_run   = en;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            w_carry[i] = w_run;
            w_run      = w_run & count[i];
            w_match[i] = r_div[i] ? count[i] : w_cnt_qb[i];
        end
    end

    assign w_wrap = en & ~load & (&w_match);

    always_comb begin
        w_j = '0;
        w_k = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (load || w_wrap) begin
                {w_j[i], w_k[i]} = JK_RESET;
            end else begin
                w_j[i] = w_carry[i];
                w_k[i] = w_carry[i];
            end
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_cnt
        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (w_j[g]),
            .k     (w_k[g]),
            .q     (count[g]),
            .qb    (w_cnt_qb[g])
        );
    end

    jk_cell u_out (
        .clk   (clk),
        .reset (reset),
        .j     (w_wrap),
        .k     (w_wrap),
        .q     (q),
        .qb    (qb)
    );

    assign tc = r_tc;

endmodule

// File: tb/tb_jk_freq_divider.sv
// Randomized and directed checks of jk_freq_divider against an arithmetic reference model.
module tb_jk_freq_divider;

    logic       clk;
    logic       reset;
    logic       en;
    logic       load;
    logic [7:0] div_val;
    logic [7:0] count;
    logic       tc;
    logic       q;
    logic       qb;

    int unsigned n_cmp;
    int unsigned n_err;

    // Reference model state
    int unsigned m_cnt;
    int unsigned m_div;
    int unsigned m_tc;
    int unsigned m_q;

    jk_freq_divider #(
        .WIDTH   (8),
        .DIV_RST (8'hFF)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .load    (load),
        .div_val (div_val),
        .count   (count),
        .tc      (tc),
        .q       (q),
        .qb      (qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic [7:0] d);
        @(negedge clk);
        reset   = r;
        load    = l;
        en      = e;
        div_val = d;
        @(posedge clk);
        if (r) begin
            m_cnt = 0; m_div = 255; m_tc = 0; m_q = 0;
        end else if (l) begin
            m_div = d; m_cnt = 0; m_tc = 0;
        end else if (e) begin
            if (m_cnt == m_div) begin
                m_cnt = 0; m_tc = 1; m_q = 1 - m_q;
            end else begin
                m_cnt = m_cnt + 1; m_tc = 0;
            end
        end else begin
            m_tc = 0;
        end
        #1;
        chk("count", count, m_cnt);
        chk("tc", tc, m_tc);
        chk("q", q, m_q);
        chk("qb", qb, 1 - m_q);
    endtask

    // Count enabled edges until tc rises, bounded.
    task automatic measure(input string tag, input int unsigned exp);
        int unsigned n;
        n = 0;
        do begin
            step(1'b0, 1'b0, 1'b1, 8'h00);
            n++;
        end while (tc !== 1'b1 && n < 400);
        chk(tag, n, exp);
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        m_cnt = 0; m_div = 255; m_tc = 0; m_q = 0;
        reset = 1'b0; load = 1'b0; en = 1'b0; div_val = '0;

        // Reset with load and en asserted; divisor must come back as 0xFF.
        step(1'b1, 1'b1, 1'b1, 8'h05);
        step(1'b1, 1'b1, 1'b1, 8'h05);
        chk("rst_count", count, 0);
        chk("rst_q", q, 0);
        chk("rst_qb", qb, 1);
        measure("rst_period", 256);

        // Divide-by-4 and q period of 8.
        step(1'b0, 1'b1, 1'b0, 8'd3);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Divisor 0: tc every enabled edge.
        step(1'b0, 1'b1, 1'b1, 8'd0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 8'h00);

        // Enable gating at count 2.
        step(1'b0, 1'b1, 1'b0, 8'd3);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 8'h00);
        chk("gate_hold", count, 2);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("gate_tc1", tc, 0);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("gate_tc2", tc, 1);

        // Load mid-count: next wrap after 6 enabled edges.
        step(1'b0, 1'b0, 1'b1, 8'h00);
        step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("mid_cnt", count, 2);
        step(1'b0, 1'b1, 1'b1, 8'd5);
        chk("mid_load", count, 0);
        measure("mid_period", 6);

        // Reset mid-operation at count 4.
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 8'h00);
        chk("rst2_pre", count, 4);
        step(1'b1, 1'b1, 1'b1, 8'd5);
        measure("rst2_period", 256);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            logic [7:0] d;
            d = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 9));
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 14) == 0),
                 ($urandom_range(0, 3) != 0), d);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
